// File: rtl/out_port_fifo_pkg.sv
// Shared constants for the CPU output port: bus select codes and status word bit positions.
package out_port_pkg;
   localparam logic SEL_DATA   = 1'b0;
   localparam logic SEL_STATUS = 1'b1;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_CNT_LSB = 3;
endpackage

// File: rtl/out_port_fifo_sync_fifo.sv
// Generic synchronous FIFO: head is combinational from storage, push while full is only taken with a pop.
// Storage is not reset; only pointers and count are.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_push_ok,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_pop_ok;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_pop_ok  = i_pop && !o_empty;
   // A pop in the same edge frees the slot the push needs.
   assign o_push_ok = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge clk) begin
      if (o_push_ok)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (o_push_ok)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop_ok)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         if (o_push_ok && !w_pop_ok)
            r_count <= r_count + CW'(1);
         else if (!o_push_ok && w_pop_ok)
            r_count <= r_count - CW'(1);
      end
   end
endmodule

// File: rtl/out_port_fifo.sv
// CPU output port: bus writes queue into a FIFO drained by valid/ready; bus reads return shadow or status.
// Optional low-water interrupt is built when OUT_PORT_FIFO_IRQ_EN is defined.
module out_port_fifo
   import out_port_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
`ifdef OUT_PORT_FIFO_IRQ_EN
   parameter int LOW_WATER = 1,
`endif
   localparam int CW = $clog2(DEPTH) + 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             read,
   input  logic             write,
   input  logic             sel,
   inout  wire  [WIDTH-1:0] data_bus,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             full,
   output logic             empty,
   output logic             overflow
`ifdef OUT_PORT_FIFO_IRQ_EN
   ,
   output logic             irq
`endif
);
   logic [WIDTH-1:0] r_shadow;
   logic             r_ovf;
   logic [WIDTH-1:0] w_status;
   logic [CW-1:0]    w_count;
   logic             w_push_req;
   logic             w_push_ok;
   logic             w_pop;

   assign w_push_req = write && (sel == SEL_DATA);
   assign w_pop      = out_valid && out_ready;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_push_req),
      .i_wdata   (data_bus),
      .i_pop     (out_ready),
      .o_rdata   (out_data),
      .o_push_ok (w_push_ok),
      .o_count   (w_count),
      .o_full    (full),
      .o_empty   (empty)
   );

   assign out_valid = !empty;
   assign overflow  = r_ovf;

   // A dropped write in the same edge as a status read keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push_ok)
            r_shadow <= data_bus;
         if (w_push_req && !w_push_ok)
            r_ovf <= 1'b1;
         else if (read && (sel == SEL_STATUS))
            r_ovf <= 1'b0;
      end
   end

`ifdef OUT_PORT_FIFO_IRQ_EN
   logic          r_tx_started;
   logic          r_irq;
   logic [CW-1:0] w_count_next;

   always_comb begin
      w_count_next = w_count;
      if (w_push_ok && !w_pop)
         w_count_next = w_count + CW'(1);
      else if (!w_push_ok && w_pop)
         w_count_next = w_count - CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_started <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         if (w_push_ok)
            r_tx_started <= 1'b1;
         r_irq <= (int'(w_count_next) <= LOW_WATER) && r_tx_started;
      end
   end

   assign irq = r_irq;
`endif

   always_comb begin
      w_status                     = '0;
      w_status[ST_EMPTY]           = empty;
      w_status[ST_FULL]            = full;
      w_status[ST_OVF]             = r_ovf;
      w_status[ST_CNT_LSB +: CW]   = w_count;
`ifdef OUT_PORT_FIFO_IRQ_EN
      w_status[ST_CNT_LSB + CW]    = r_irq;
`endif
   end

   assign data_bus = read ? ((sel == SEL_STATUS) ? w_status : r_shadow) : 'z;
endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo (WIDTH=16, DEPTH=4); irq checks are built with OUT_PORT_FIFO_IRQ_EN.
module tb_out_port_fifo;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic        sel = 1'b0;
   logic        out_ready = 1'b0;
   logic        tb_drv = 1'b0;
   logic [15:0] tb_dat = '0;
   wire  [15:0] data_bus;
   logic [15:0] out_data;
   logic        out_valid, full, empty, overflow;
`ifdef OUT_PORT_FIFO_IRQ_EN
   logic        irq;
   localparam logic [15:0] IRQ_BIT = 16'h0040;
`else
   localparam logic [15:0] IRQ_BIT = 16'h0000;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   assign data_bus = tb_drv ? tb_dat : 'z;
   for (genvar g = 0; g < 16; g++) begin : g_pd
      pulldown (data_bus[g]);
   end

   out_port_fifo #(.WIDTH(16), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .read      (read),
      .write     (write),
      .sel       (sel),
      .data_bus  (data_bus),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
`ifdef OUT_PORT_FIFO_IRQ_EN
      ,
      .irq       (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d);
      tb_dat = d;
      tb_drv = 1'b1;
      write  = 1'b1;
      sel    = 1'b0;
      cyc();
      write  = 1'b0;
      tb_drv = 1'b0;
   endtask

   task automatic bus_read(input logic s, output logic [15:0] v);
      read = 1'b1;
      sel  = s;
      #1;
      v = data_bus;
      cyc();
      read = 1'b0;
      sel  = 1'b0;
      #1;
   endtask

   initial begin
      logic [15:0] v;
      logic [15:0] drain_exp [4];
      drain_exp[0] = 16'h2222;
      drain_exp[1] = 16'h3333;
      drain_exp[2] = 16'h4444;
      drain_exp[3] = 16'h5555;

      #3;
      check("rst_valid", {15'd0, out_valid}, 16'd0);
      check("rst_empty", {15'd0, empty}, 16'd1);
      check("rst_full", {15'd0, full}, 16'd0);
      check("rst_ovf", {15'd0, overflow}, 16'd0);
      #9 reset = 1'b0;
      cyc();

      // Async reset while holding three entries
      push(16'h0001); push(16'h0002); push(16'h0003);
      check("pre_rst_valid", {15'd0, out_valid}, 16'd1);
      check("pre_rst_head", out_data, 16'h0001);
      #3 reset = 1'b1;
      #1;
      check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
      check("mid_rst_empty", {15'd0, empty}, 16'd1);
      check("mid_rst_bus_z", data_bus, 16'h0000);
      read = 1'b1; sel = 1'b1;
      #1;
      check("mid_rst_status", data_bus, 16'h0001);
      read = 1'b0; sel = 1'b0;
      #1 reset = 1'b0;
      cyc();

      // Fill to full with the consumer stalled
      push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
      check("fill_full", {15'd0, full}, 16'd1);
      check("fill_head", out_data, 16'h1111);
      bus_read(1'b1, v);
      check("fill_status", v, 16'h0022);

      // Dropped write while full
      push(16'hDEAD);
      check("ovf_flag", {15'd0, overflow}, 16'd1);
      bus_read(1'b0, v);
      check("ovf_shadow", v, 16'h4444);
      bus_read(1'b1, v);
      check("ovf_status1", v, 16'h0026);
      bus_read(1'b1, v);
      check("ovf_status2", v, 16'h0022);
      check("ovf_cleared", {15'd0, overflow}, 16'd0);

      // Push and pop on the same edge while full
      out_ready = 1'b1;
      push(16'h5555);
      out_ready = 1'b0;
      #1;
      check("simul_full", {15'd0, full}, 16'd1);
      check("simul_head", out_data, 16'h2222);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("drain_%0d", i), out_data, drain_exp[i]);
         cyc();
      end
      out_ready = 1'b0;
      check("drain_empty", {15'd0, empty}, 16'd1);
      check("drain_valid", {15'd0, out_valid}, 16'd0);

      // Shadow readback, undriven bus, ignored status-select write
      push(16'hA5A5);
      bus_read(1'b0, v);
      check("rb_shadow", v, 16'hA5A5);
      check("rb_bus_z", data_bus, 16'h0000);
      tb_dat = 16'h7777; tb_drv = 1'b1; write = 1'b1; sel = 1'b1;
      cyc();
      write = 1'b0; tb_drv = 1'b0; sel = 1'b0;
      #1;
      bus_read(1'b1, v);
      check("sel1_wr_status", v, 16'h0008 | IRQ_BIT);
      bus_read(1'b0, v);
      check("sel1_wr_shadow", v, 16'hA5A5);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      check("rb_pop_empty", {15'd0, empty}, 16'd1);

`ifdef OUT_PORT_FIFO_IRQ_EN
      push(16'h0101); push(16'h0202); push(16'h0303);
      check("irq_low_3", {15'd0, irq}, 16'd0);
      out_ready = 1'b1;
      cyc();
      check("irq_at_2", {15'd0, irq}, 16'd0);
      cyc();
      check("irq_at_1", {15'd0, irq}, 16'd1);
      check("irq_head", out_data, 16'h0303);
      cyc();
      check("irq_at_0", {15'd0, irq}, 16'd1);
      out_ready = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/out_port_fifo.md
Name: out_port_fifo

Overview:
Parametrised successor to the single-register output port on the shared CPU data bus. CPU writes from the tri-state bus are queued in a DEPTH-entry FIFO. The FIFO drains to an external consumer over a valid/ready handshake. The CPU can read back the last written value or a status word through the same tri-state bus, with bus select chosen by `sel`.

Parameters:
- WIDTH, 16, bus and data width in bits; must satisfy WIDTH >= 3 + CW.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- CW, $clog2(DEPTH)+1, count width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- read  in  1  CPU read strobe; enables the bus driver.
- write  in  1  CPU write strobe; push request.
- sel  in  1  0 = data (shadow) register, 1 = status word.
- data_bus  inout  WIDTH  shared CPU bus.
- out_data  out  WIDTH  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: write was dropped.

Behaviour:
- Reset (async, any time including mid-transfer):
  - count=0, rd/wr pointers=0, shadow=0, overflow=0.
  - out_valid=0, empty=1, full=0, data_bus=Z.
  - FIFO storage is not cleared; contents are don't-care.
- Pop: when out_valid && out_ready at a rising edge, the head advances. out_data is combinational from storage[rd_ptr]; no added latency.
- Push: write && sel==0 at a rising edge.
  - If !full or pop in the same cycle: storage[wr_ptr] <= data_bus, wr_ptr increments, shadow <= data_bus.
  - If full and no pop: data is dropped, overflow <= 1, shadow unchanged.
- Simultaneous push and pop: count unchanged. When empty, push and pop cannot coincide, because out_valid=0.
- write && sel==1: ignored; no state change.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH naturally.
- Count: CW bits, +1 on push only, -1 on pop only.
- Status word (WIDTH bits):
  - bit0 = empty, bit1 = full, bit2 = overflow.
  - bits[3+CW-1:3] = count; remaining bits 0.
- Bus drive: data_bus = read ? (sel ? status : shadow) : Z. Combinational, same cycle.
- overflow is clear-on-read: read && sel==1 at a rising edge clears it.
  - If a dropped write occurs in the same edge, set wins (overflow stays 1).
- read && write in the same cycle is a CPU protocol error. The driver still follows `read`; the push follows the rules above.
- full, empty, and out_valid are derived from registered count; no combinational path from the `write` input.

Optional Feature:
- Macro OUT_PORT_FIFO_IRQ_EN.
- Defined:
  - Adds parameter LOW_WATER (default 1) and output `irq` (1 bit).
  - irq is a registered flag: irq <= (count_next <= LOW_WATER) && tx_started.
  - tx_started sets on the first accepted push and clears on reset.
  - irq resets to 0.
  - Status bit 3+CW reports irq; this requires WIDTH >= 4 + CW.
- Undefined: no irq port, no LOW_WATER parameter, and status bit 3+CW reads 0.

Decomposition:
- Package out_port_pkg:
  - SEL_DATA=0, SEL_STATUS=1.
  - Status bit indices ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_CNT_LSB=3.
- Sub-module sync_fifo: WIDTH/DEPTH storage, pointers, count, push/pop/full/empty. It is reusable by future input ports.
- Top-level logic: shadow register, overflow, status mux, tri-state driver, irq.

Test Plan:
1. Reset mid-operation: load 3 entries, then assert reset asynchronously between edges → out_valid=0, empty=1, count=0, data_bus=Z immediately.
2. Fill and drain: write 0x1111, 0x2222, 0x3333, 0x4444 with out_ready=0 → full=1, status count=4. Then hold out_ready=1 → out_data presents 0x1111…0x4444 on successive cycles, then empty=1.
3. Overflow: with the FIFO full, write 0xDEAD → entry dropped, overflow=1, shadow still 0x4444. Status read gives 0x0026 (count 4, ovf, full). A second status read shows overflow=0.
4. Simultaneous: with the FIFO full, write 0x5555 while out_ready=1 → push accepted, count stays 4, last entry popped out is 0x5555.
5. Bus readback: write 0xA5A5, then read sel=0 → bus=0xA5A5. read=0 → bus=Z; a bench pull-down observes Z.
6. IRQ (macro defined, LOW_WATER=1): push 3 entries, then drain → irq asserts the cycle after count reaches 1 and stays high at 0.
